// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the single TX AXI-stream input of the RGMII MAC.
// Frames are never interleaved; over-long frames are cut with tuser=1 and the remainder drained.
//
// state | meaning
// IDLE  | no grant; pick next requester round-robin (one idle cycle between frames)
// XFER  | granted port passes through combinationally to the master side
// DRAIN | frame was truncated; swallow source beats up to its tlast
module eth_tx_frame_arbiter #(
    parameter int S_COUNT         = 4,
    parameter int AXIS_DATA_WIDTH = 8,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int MAX_BEATS       = 1518,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                 logic_clk,
    input  logic                                 logic_rst_n,
    input  logic [S_COUNT*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_COUNT*AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [S_COUNT-1:0]                   s_axis_tvalid,
    output logic [S_COUNT-1:0]                   s_axis_tready,
    input  logic [S_COUNT-1:0]                   s_axis_tlast,
    input  logic [S_COUNT-1:0]                   s_axis_tuser,
    output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic                                 m_axis_tuser,
    input  logic [S_COUNT-1:0]                   port_enable,
    output logic                                 grant_valid,
    output logic [$clog2(S_COUNT)-1:0]           grant_index,
    output logic                                 trunc_pulse,
    output logic [S_COUNT*CNT_WIDTH-1:0]         frame_count
);
    localparam int IDX_W  = $clog2(S_COUNT);
    localparam int BEAT_W = $clog2(MAX_BEATS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [CNT_WIDTH-1:0] fc_q [S_COUNT];

    logic [S_COUNT-1:0]         req;
    logic                       arb_found;
    logic [IDX_W-1:0]           arb_idx;
    logic [IDX_W-1:0]           cand;
    logic [AXIS_DATA_WIDTH-1:0] sel_data;
    logic [AXIS_KEEP_WIDTH-1:0] sel_keep;
    logic                       sel_valid;
    logic                       sel_last;
    logic                       sel_user;
    logic                       at_limit;
    logic                       force_trunc;
    logic                       m_hs;

    assign req = s_axis_tvalid & port_enable;

    // First requester strictly after rr_ptr, wrapping, so the last winner goes to the back.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % S_COUNT);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_index == IDX_W'(i)) begin
                sel_data  = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                sel_keep  = s_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i];
            end
        end
    end

    // A frame of exactly MAX_BEATS ending in tlast keeps its own tuser.
    assign at_limit    = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
    assign force_trunc = at_limit & ~sel_last;

    assign m_axis_tdata  = sel_data;
    assign m_axis_tkeep  = sel_keep;
    assign m_axis_tvalid = (state == ST_XFER) & sel_valid;
    assign m_axis_tlast  = sel_last | at_limit;
    assign m_axis_tuser  = sel_user | force_trunc;
    assign m_hs          = m_axis_tvalid & m_axis_tready;
    assign grant_valid   = (state == ST_XFER) || (state == ST_DRAIN);

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_index == IDX_W'(i)) begin
                if (state == ST_XFER)
                    s_axis_tready[i] = m_axis_tready;
                else if (state == ST_DRAIN)
                    s_axis_tready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= IDX_W'(S_COUNT - 1);
            grant_index <= '0;
            beat_cnt    <= '0;
            trunc_pulse <= 1'b0;
            for (int i = 0; i < S_COUNT; i++)
                fc_q[i] <= '0;
        end else begin
            trunc_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant_index <= arb_idx;
                        beat_cnt    <= '0;
                        state       <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (m_hs) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (sel_last || at_limit) begin
                            for (int i = 0; i < S_COUNT; i++)
                                if (grant_index == IDX_W'(i))
                                    fc_q[i] <= fc_q[i] + CNT_WIDTH'(1);
                            rr_ptr <= grant_index;
                            if (sel_last) begin
                                state <= ST_IDLE;
                            end else begin
                                trunc_pulse <= 1'b1;
                                state       <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sel_valid && sel_last)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < S_COUNT; g++) begin : g_fc
        assign frame_count[g*CNT_WIDTH +: CNT_WIDTH] = fc_q[g];
    end
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: 4 ports, MAX_BEATS=8, 4-bit frame counters.
// Source data byte is {port[1:0], beat[5:0]} so order, loss and duplication are visible.
module tb_eth_tx_frame_arbiter;
    localparam int NP = 4;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [NP*8-1:0] s_tdata;
    logic [NP-1:0]  s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
    logic [7:0]     m_tdata;
    logic [0:0]     m_tkeep;
    logic           m_tvalid, m_tready, m_tlast, m_tuser;
    logic [NP-1:0]  port_enable;
    logic           grant_valid;
    logic [1:0]     grant_index;
    logic           trunc_pulse;
    logic [NP*CW-1:0] frame_count;

    eth_tx_frame_arbiter #(
        .S_COUNT(NP), .AXIS_DATA_WIDTH(8), .MAX_BEATS(8), .CNT_WIDTH(CW)
    ) dut (
        .logic_clk(clk), .logic_rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .port_enable(port_enable), .grant_valid(grant_valid), .grant_index(grant_index),
        .trunc_pulse(trunc_pulse), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         cyc;
    } beat_t;

    int    n_chk = 0;
    int    n_pass = 0;
    int    s_len[NP], s_frames[NP], s_beat[NP], s_hs[NP];
    bit    s_ulast[NP];
    bit    rdy_mode, stall_mode;
    int    cyc;
    beat_t out_q[$];
    int    gv_log[$], tr_log[$];
    int    fr_port[$], fr_len[$], fr_user[$];
    int    seq_err, gap_err;
    bit    prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int fc(input int i);
        return int'(frame_count[i*CW +: CW]);
    endfunction

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            s_tvalid[i]       = (s_frames[i] > 0) && !(stall_mode && (cyc % 3 == 1));
            s_tdata[i*8 +: 8] = 8'(i * 64 + s_beat[i]);
            s_tlast[i]        = (s_beat[i] == s_len[i] - 1);
            s_tuser[i]        = s_tlast[i] & s_ulast[i];
            s_tkeep[i]        = 1'b1;
        end
        m_tready = rdy_mode ? (cyc % 2 == 0) : 1'b1;
    endtask

    task automatic load(input int p, input int len, input int frames, input bit ulast);
        s_len[p] = len; s_frames[p] = frames; s_beat[p] = 0; s_ulast[p] = ulast;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NP; i++) begin
            load(i, 1, 0, 1'b0);
            s_hs[i] = 0;
        end
        out_q.delete(); gv_log.delete(); tr_log.delete();
        gap_err = 0; prev_last = 1'b0; cyc = 0;
        rdy_mode = 1'b0; stall_mode = 1'b0; port_enable = '1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive();
    endtask

    // One clock: capture the handshakes about to happen, cross the edge, advance sources.
    task automatic tick();
        logic [NP-1:0] hs;
        beat_t b;
        #1;
        hs = s_tvalid & s_tready;
        gv_log.push_back(int'(grant_valid));
        if (prev_last && m_tvalid) gap_err++;
        prev_last = m_tvalid && m_tready && m_tlast;
        if (m_tvalid && m_tready) begin
            b.data = m_tdata; b.last = m_tlast; b.user = m_tuser; b.cyc = cyc;
            out_q.push_back(b);
        end
        @(posedge clk);
        #1;
        tr_log.push_back(int'(trunc_pulse));
        for (int i = 0; i < NP; i++) begin
            if (hs[i]) begin
                s_hs[i]++;
                if (s_tlast[i]) begin
                    s_beat[i] = 0;
                    s_frames[i]--;
                end else begin
                    s_beat[i]++;
                end
            end
        end
        cyc++;
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic analyze();
        int blen;
        logic [1:0] port;
        fr_port.delete(); fr_len.delete(); fr_user.delete();
        seq_err = 0; blen = 0; port = '0;
        foreach (out_q[k]) begin
            if (blen == 0) port = out_q[k].data[7:6];
            if (out_q[k].data !== {port, 6'(blen)}) seq_err++;
            blen++;
            if (out_q[k].last) begin
                fr_port.push_back(int'(port));
                fr_len.push_back(blen);
                fr_user.push_back(int'(out_q[k].user));
                blen = 0;
            end
        end
    endtask

    initial begin
        clear_all();
        load(0, 4, 1, 1'b0);
        drive();
        // reset values while a source is already offering data
        #1 rst_n = 1'b0;
        #2;
        check("rst_tready", s_tready, 0);
        check("rst_mvalid", m_tvalid, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_index", grant_index, 0);
        check("rst_trunc", trunc_pulse, 0);
        check("rst_frame_count", frame_count, 0);

        // single 4-beat frame from port 0
        do_reset();
        load(0, 4, 1, 1'b0); drive();
        run(8);
        analyze();
        check("t1_gv_idle_c0", qget(gv_log, 0), 0);
        check("t1_beats", out_q.size(), 4);
        check("t1_first_cyc", (out_q.size() > 0) ? out_q[0].cyc : -1, 1);
        check("t1_frames", fr_len.size(), 1);
        check("t1_len", qget(fr_len, 0), 4);
        check("t1_seq", seq_err, 0);
        check("t1_grant_index", grant_index, 0);
        check("t1_fc0", fc(0), 1);
        check("t1_gv_after", qget(gv_log, 5), 0);
        check("t1_gap", gap_err, 0);

        // three ports with continuous 3-beat frames: strict round robin
        do_reset();
        for (int p = 0; p < 3; p++) load(p, 3, 2, 1'b0);
        drive();
        run(30);
        analyze();
        check("t2_frames", fr_port.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t2_port%0d", k), qget(fr_port, k), k % 3);
            check($sformatf("t2_len%0d", k), qget(fr_len, k), 3);
        end
        check("t2_seq", seq_err, 0);
        check("t2_gap", gap_err, 0);
        check("t2_fc", frame_count, 16'h0222);

        // 12-beat frame on port 1 truncated at 8 beats, rest drained
        do_reset();
        load(1, 12, 1, 1'b0); drive();
        run(16);
        analyze();
        check("t3_out_beats", out_q.size(), 8);
        check("t3_len", qget(fr_len, 0), 8);
        check("t3_user", qget(fr_user, 0), 1);
        check("t3_seq", seq_err, 0);
        check("t3_src_hs", s_hs[1], 12);
        check("t3_trunc_at", qget(tr_log, 8), 1);
        check("t3_trunc_cnt", tr_log.sum(), 1);
        check("t3_gv_drain", qget(gv_log, 12), 1);
        check("t3_gv_done", qget(gv_log, 13), 0);
        check("t3_fc1", fc(1), 1);

        // exactly MAX_BEATS ending in tlast: no truncation
        do_reset();
        load(1, 8, 1, 1'b0); drive();
        run(12);
        analyze();
        check("t4_len", qget(fr_len, 0), 8);
        check("t4_user", qget(fr_user, 0), 0);
        check("t4_trunc_cnt", tr_log.sum(), 0);
        check("t4_gv_after", qget(gv_log, 9), 0);
        check("t4_fc1", fc(1), 1);

        // source tuser passes through on a normal frame
        do_reset();
        load(2, 3, 1, 1'b1); drive();
        run(6);
        analyze();
        check("t4b_user", qget(fr_user, 0), 1);
        check("t4b_trunc_cnt", tr_log.sum(), 0);

        // port 3 with toggling ready and valid gaps; disabled mid-frame
        do_reset();
        rdy_mode = 1'b1; stall_mode = 1'b1;
        load(3, 6, 2, 1'b0); drive();
        run(4);
        port_enable[3] = 1'b0;
        run(40);
        analyze();
        check("t5_frames_dis", fr_port.size(), 1);
        check("t5_port", qget(fr_port, 0), 3);
        check("t5_len", qget(fr_len, 0), 6);
        check("t5_seq", seq_err, 0);
        check("t5_src_hs", s_hs[3], 6);
        check("t5_fc3_dis", fc(3), 1);
        check("t5_gv_idle", grant_valid, 0);
        port_enable[3] = 1'b1;
        run(40);
        analyze();
        check("t5_fc3_en", fc(3), 2);
        check("t5_src_hs_en", s_hs[3], 12);
        check("t5_seq_en", seq_err, 0);

        // reset in the middle of a port 2 frame
        do_reset();
        load(2, 2, 1, 1'b0); drive();
        run(5);
        check("t6_fc2_pre", fc(2), 1);
        load(2, 6, 1, 1'b0); drive();
        run(3);
        #2;
        check("t6_mvalid_pre", m_tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_mvalid", m_tvalid, 0);
        check("t6_rst_tready", s_tready, 0);
        check("t6_rst_fc", frame_count, 0);
        check("t6_rst_gv", grant_valid, 0);
        do_reset();
        load(0, 2, 1, 1'b0); load(2, 2, 1, 1'b0); drive();
        run(10);
        analyze();
        check("t6_first_port", qget(fr_port, 0), 0);
        check("t6_second_port", qget(fr_port, 1), 2);

        // frame counter wraps at 2^CNT_WIDTH
        do_reset();
        load(0, 2, 17, 1'b0); drive();
        run(60);
        analyze();
        check("t7_frames", fr_port.size(), 17);
        check("t7_fc0_wrap", fc(0), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
